ac97_link_framer: RTL and testbench
===================================

Name: ac97_link_framer

Overview:
- AC'97 link-layer engine directly upstream of the audio processing stage, running on the codec BIT_CLK (12.288 MHz).
- Generates SYNC, serialises outgoing 256-bit frames (tag, one register-write command, PCM left/right) onto SDATA_OUT, and deserialises SDATA_IN.
- Delivers received PCM slots 3/4 as left_in/right_in with a one-clock ready strobe per frame; accepts processed left_out/right_out for transmission.

Parameters:
- PCM_WIDTH, 20, sample width of slots 3/4, both directions.
- FRAME_BITS, 256, bits per frame. Fixed by AC'97; no other value supported.

Ports:
- clock  in  1  BIT_CLK from codec; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sync  out  1  AC'97 SYNC.
- sdata_out  out  1  serial frame to codec.
- sdata_in  in  1  serial frame from codec.
- left_out  in  PCM_WIDTH  processed left sample to transmit (slot 3).
- right_out  in  PCM_WIDTH  processed right sample to transmit (slot 4).
- left_in  out  PCM_WIDTH  last received left sample (slot 3).
- right_in  out  PCM_WIDTH  last received right sample (slot 4).
- ready  out  1  one-clock strobe: left_in/right_in just updated.
- codec_ready  out  1  received slot-0 bit 15 of most recent frame.
- cmd_valid  in  1  register-write request.
- cmd_ready  out  1  command buffer empty.
- cmd_addr  in  7  codec register index.
- cmd_data  in  16  register write data.

Behaviour:
- Reset (async assert, released synchronously to clock):
  - bit_cnt=0; sync, sdata_out, ready, codec_ready = 0; left_in, right_in = 0.
  - cmd_ready=0 while reset_n low, 1 on first clock after release.
  - Buffered command discarded. Reset mid-frame aborts the frame; next frame starts at bit 0.
- Frame counter bit_cnt:
  - Counts 0..255 and wraps 255->0.
  - Slot 0 occupies bits 0-15. Slot k (1..12) occupies bits 16+20(k-1) .. 35+20(k-1). Slot 3 = 56-75, slot 4 = 76-95.
  - All slots MSB first.
- Transmit (sync, sdata_out are registers):
  - During the cycle in which bit_cnt==n, they carry frame bit n.
  - sync=1 for n in 0..15, else 0.
- Slot 0 tag:
  - bit15 = 1.
  - bit14 = bit13 = command pending.
  - bit12 = bit11 = 1.
  - bits 10..0 = 0.
- Slot 1: bit19 = 0 (write), bits 18:12 = cmd_addr, rest 0; all zero if no command.
- Slot 2: bits 19:4 = cmd_data, bits 3:0 = 0; all zero if no command.
- Slots 3/4: left_out/right_out snapshotted on the edge where bit_cnt becomes 0. Input changes later in the frame do not affect it.
- Slots 5-12: transmitted as 0.
- Command handshake:
  - Accepted on the edge with cmd_valid && cmd_ready; cmd_ready drops next cycle.
  - Pending flag, address and data are sampled at the frame snapshot (bit_cnt becomes 0).
  - Command accepted on the edge where bit_cnt 255->0 goes in the next frame, not the current one.
  - cmd_ready returns to 1 on the edge after bit 55 (end of slot 2) of the frame that carried it.
  - Exactly one frame per command.
- Receive:
  - sdata_in sampled on the rising edge ending the cycle with bit_cnt==n is frame bit n.
  - Shift register collects slots 0, 3, 4.
  - codec_ready updates when bit 0 is captured.
  - After bit 95 is captured: if received tag bit15, bit12 and bit11 are all 1, then on the next edge left_in<=slot3, right_in<=slot4, and ready=1 for exactly one clock.
  - Otherwise outputs hold and there is no strobe.
  - At most one ready pulse per frame.
- Simultaneous events: a command accepted on the same edge as a snapshot is not in that frame. A received frame and a transmitted frame share bit_cnt; no independent alignment.

Decomposition:
- Package ac97_pkg holds:
  - FRAME_BITS, slot start constants (SLOT0_START=0, SLOT1_START=16, SLOT2_START=36, SLOT3_START=56, SLOT4_START=76).
  - Tag bit positions (TAG_VALID=15, TAG_CMD_ADDR=14, TAG_CMD_DATA=13, TAG_PCM_L=12, TAG_PCM_R=11).
- One sub-module: ac97_rx_deframer (receive shift, slot capture, ready/codec_ready generation), driven by the shared bit_cnt.

Test Plan:
- Reset then free-run 3 frames -> sync high exactly bits 0-15 of every 256-clock period; ready stays 0 with sdata_in=0; cmd_ready=1 one clock after release.
- left_out=20'hABCDE, right_out=20'h12345 held -> sdata_out bits 56-75 = ABCDE MSB first, bits 76-95 = 12345; slot-0 tag = 16'h9800.
- Bench codec drives tag 16'h9800, slot3=20'h0F0F0, slot4=20'hFFFFF -> ready pulses once, one clock after bit 95; left_in=0F0F0, right_in=FFFFF; codec_ready=1.
- Same frame with tag bit12=0 -> no ready pulse; left_in/right_in hold previous values.
- cmd_valid with addr=7'h02, data=16'h0808 mid-frame -> next frame tag=16'hF800, slot1=20'h02000, slot2=20'h08080; cmd_ready low until after bit 55, then 1; following frame tag=16'h9800.
- reset_n pulsed low at bit_cnt=40 with a command buffered -> sync, sdata_out, ready = 0 immediately; after release frame restarts at bit 0; command not transmitted.

Source files
------------

// File: rtl/ac97_pkg.sv
// Shared AC'97 frame geometry, tag bit positions and command-buffer states
// for the link framer and its receive deframer.
package ac97_pkg;

  localparam int FRAME_BITS = 256;

  localparam logic [7:0] SLOT_BITS   = 8'd20;
  localparam logic [7:0] SLOT0_START = 8'd0;
  localparam logic [7:0] SLOT1_START = 8'd16;
  localparam logic [7:0] SLOT2_START = 8'd36;
  localparam logic [7:0] SLOT3_START = 8'd56;
  localparam logic [7:0] SLOT4_START = 8'd76;

  localparam logic [7:0] SLOT2_END = SLOT2_START + SLOT_BITS - 8'd1;
  localparam logic [7:0] SLOT4_END = SLOT4_START + SLOT_BITS - 8'd1;

  localparam int TAG_VALID    = 15;
  localparam int TAG_CMD_ADDR = 14;
  localparam int TAG_CMD_DATA = 13;
  localparam int TAG_PCM_L    = 12;
  localparam int TAG_PCM_R    = 11;

  // Lifecycle of the single-entry register-write buffer.
  typedef enum logic [1:0] {
    CMD_RESET,
    CMD_IDLE,
    CMD_HELD,
    CMD_SEND
  } cmd_state_t;

endpackage

// File: rtl/ac97_rx_deframer.sv
// Receive side of the AC'97 link: collects slots 0/3/4 from sdata_in using the
// shared frame counter and publishes PCM samples with a one-clock ready strobe.
module ac97_rx_deframer
  import ac97_pkg::*;
#(
  parameter int PCM_WIDTH = 20
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 active,
  input  logic [7:0]           bit_cnt,
  input  logic                 sdata_in,
  output logic [PCM_WIDTH-1:0] left_in,
  output logic [PCM_WIDTH-1:0] right_in,
  output logic                 ready,
  output logic                 codec_ready
);

  localparam int RX_BITS = 16 + 2 * PCM_WIDTH;
  localparam int TAG_LSB = RX_BITS - 16;

  logic [RX_BITS-1:0] rx_shift;
  logic               capture;
  logic               slots_done;
  logic               tag_ok;

  // Only slot 0 and slots 3/4 enter the shift register, so after bit 95 the
  // tag sits on top, slot 3 in the middle and slot 4 at the bottom.
  assign capture    = active && ((bit_cnt < SLOT1_START) ||
                                 ((bit_cnt >= SLOT3_START) && (bit_cnt <= SLOT4_END)));
  assign slots_done = active && (bit_cnt == SLOT4_END + 8'd1);
  assign tag_ok     = rx_shift[TAG_LSB + TAG_VALID] &&
                      rx_shift[TAG_LSB + TAG_PCM_L] &&
                      rx_shift[TAG_LSB + TAG_PCM_R];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_shift    <= '0;
      left_in     <= '0;
      right_in    <= '0;
      ready       <= 1'b0;
      codec_ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (capture) begin
        rx_shift <= {rx_shift[RX_BITS-2:0], sdata_in};
      end
      if (active && (bit_cnt == SLOT0_START)) begin
        codec_ready <= sdata_in;
      end
      if (slots_done && tag_ok) begin
        left_in  <= rx_shift[2*PCM_WIDTH-1 -: PCM_WIDTH];
        right_in <= rx_shift[PCM_WIDTH-1:0];
        ready    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ac97_link_framer.sv
// AC'97 link framer: SYNC generation, outgoing frame serialisation with one
// buffered register write per frame, and receive deframing via ac97_rx_deframer.
module ac97_link_framer
  import ac97_pkg::*;
#(
  parameter int PCM_WIDTH  = 20,
  parameter int FRAME_BITS = ac97_pkg::FRAME_BITS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic                 sync,
  output logic                 sdata_out,
  input  logic                 sdata_in,
  input  logic [PCM_WIDTH-1:0] left_out,
  input  logic [PCM_WIDTH-1:0] right_out,
  output logic [PCM_WIDTH-1:0] left_in,
  output logic [PCM_WIDTH-1:0] right_in,
  output logic                 ready,
  output logic                 codec_ready,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [6:0]           cmd_addr,
  input  logic [15:0]          cmd_data
);

  localparam logic [7:0] FRAME_LAST = 8'(FRAME_BITS - 1);
  localparam int         TX_BITS    = 15 + 2 * 20 + 2 * PCM_WIDTH;

  logic [7:0]         bit_cnt;
  logic               running;
  logic               frame_start;
  logic [TX_BITS-1:0] tx_shift;
  logic [15:0]        tx_tag;
  logic [19:0]        tx_slot1;
  logic [19:0]        tx_slot2;

  cmd_state_t         cmd_state;
  cmd_state_t         cmd_state_nxt;
  logic               cmd_accept;
  logic               cmd_pending;
  logic [6:0]         cmd_addr_q;
  logic [15:0]        cmd_data_q;

  // The first edge after reset release opens frame bit 0, so every frame,
  // including the first, shows SYNC on exactly bits 0..15.
  assign frame_start = !running || (bit_cnt == FRAME_LAST);
  assign cmd_pending = (cmd_state == CMD_HELD);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready stays low until the carrying frame has
  // finished slot 2, so the buffer never holds more than one command.
  always_comb begin
    cmd_state_nxt = cmd_state;
    cmd_ready     = 1'b0;
    cmd_accept    = 1'b0;
    case (cmd_state)
      CMD_RESET: cmd_state_nxt = CMD_IDLE;
      CMD_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_accept    = 1'b1;
          cmd_state_nxt = CMD_HELD;
        end
      end
      CMD_HELD: if (frame_start) cmd_state_nxt = CMD_SEND;
      CMD_SEND: if (bit_cnt == SLOT2_END) cmd_state_nxt = CMD_IDLE;
      default:  cmd_state_nxt = CMD_RESET;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_state  <= CMD_RESET;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else begin
      cmd_state <= cmd_state_nxt;
      if (cmd_accept) begin
        cmd_addr_q <= cmd_addr;
        cmd_data_q <= cmd_data;
      end
    end
  end

  always_comb begin
    tx_tag               = '0;
    tx_tag[TAG_VALID]    = 1'b1;
    tx_tag[TAG_CMD_ADDR] = cmd_pending;
    tx_tag[TAG_CMD_DATA] = cmd_pending;
    tx_tag[TAG_PCM_L]    = 1'b1;
    tx_tag[TAG_PCM_R]    = 1'b1;
    tx_slot1             = '0;
    tx_slot2             = '0;
    if (cmd_pending) begin
      tx_slot1 = {1'b0, cmd_addr_q, 12'h000};
      tx_slot2 = {cmd_data_q, 4'h0};
    end
  end

  // Bit 0 is driven directly on the snapshot edge; the rest of slots 0..4 is
  // parked in tx_shift and zero-fill covers slots 5..12.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running   <= 1'b0;
      bit_cnt   <= '0;
      sync      <= 1'b0;
      sdata_out <= 1'b0;
      tx_shift  <= '0;
    end else if (frame_start) begin
      running   <= 1'b1;
      bit_cnt   <= '0;
      sync      <= 1'b1;
      sdata_out <= tx_tag[TAG_VALID];
      tx_shift  <= {tx_tag[TAG_VALID-1:0], tx_slot1, tx_slot2, left_out, right_out};
    end else begin
      bit_cnt   <= bit_cnt + 8'd1;
      sync      <= (bit_cnt + 8'd1) < SLOT1_START;
      sdata_out <= tx_shift[TX_BITS-1];
      tx_shift  <= {tx_shift[TX_BITS-2:0], 1'b0};
    end
  end

  ac97_rx_deframer #(
    .PCM_WIDTH (PCM_WIDTH)
  ) u_rx (
    .clock       (clock),
    .reset_n     (reset_n),
    .active      (running),
    .bit_cnt     (bit_cnt),
    .sdata_in    (sdata_in),
    .left_in     (left_in),
    .right_in    (right_in),
    .ready       (ready),
    .codec_ready (codec_ready)
  );

endmodule

// File: tb/tb_ac97_link_framer.sv
// Randomised bench for ac97_link_framer: a frame-level codec/host model predicts
// every transmitted frame, the received samples and the command handshake.
module tb_ac97_link_framer;

  localparam int PCM_WIDTH = 20;

  logic        clock       = 1'b0;
  logic        reset_n     = 1'b0;
  logic        sync;
  logic        sdata_out;
  logic        sdata_in    = 1'b0;
  logic [19:0] left_out    = '0;
  logic [19:0] right_out   = '0;
  logic [19:0] left_in;
  logic [19:0] right_in;
  logic        ready;
  logic        codec_ready;
  logic        cmd_valid   = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_addr    = '0;
  logic [15:0] cmd_data    = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: frame position is -1 until the first frame opens.
  int          pos           = -1;
  logic [95:0] exp_q[$];
  logic [55:0] rx_plan       = '0;
  logic [55:0] rx_cur        = '0;
  logic        exp_ready     = 1'b0;
  logic        exp_codec     = 1'b0;
  logic        exp_cmd_ready = 1'b0;
  logic [19:0] exp_left      = '0;
  logic [19:0] exp_right     = '0;
  bit          cmd_waiting   = 1'b0;
  bit          cmd_carrying  = 1'b0;
  logic [6:0]  w_addr        = '0;
  logic [15:0] w_data        = '0;
  logic [255:0] obs_sync     = '0;
  logic [255:0] obs_tx       = '0;

  ac97_link_framer #(
    .PCM_WIDTH (PCM_WIDTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sync        (sync),
    .sdata_out   (sdata_out),
    .sdata_in    (sdata_in),
    .left_out    (left_out),
    .right_out   (right_out),
    .left_in     (left_in),
    .right_in    (right_in),
    .ready       (ready),
    .codec_ready (codec_ready),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] tx_frame(input bit incl, input logic [6:0] a,
                                           input logic [15:0] d, input logic [19:0] l,
                                           input logic [19:0] r);
    logic [15:0] tag;
    logic [19:0] s1;
    logic [19:0] s2;
    tag = 16'h9800;
    s1  = '0;
    s2  = '0;
    if (incl) begin
      tag = tag | 16'h6000;
      s1  = {1'b0, a, 12'h000};
      s2  = {d, 4'h0};
    end
    return {tag, s1, s2, l, r};
  endfunction

  // Model update on each edge from the inputs the DUT sees, then output checks.
  always @(posedge clock) begin : monitor
    int          pre;
    bit          start;
    bit          acc;
    logic [15:0] rtag;
    logic [95:0] exp_frame;
    if (!reset_n) begin
      pos           = -1;
      exp_q.delete();
      cmd_waiting   = 1'b0;
      cmd_carrying  = 1'b0;
      exp_cmd_ready = 1'b0;
      exp_ready     = 1'b0;
      exp_codec     = 1'b0;
      exp_left      = '0;
      exp_right     = '0;
    end else begin
      pre       = pos;
      acc       = cmd_valid && exp_cmd_ready;
      start     = (pre < 0) || (pre == 255);
      exp_ready = 1'b0;
      if (start) begin
        exp_q.push_back(tx_frame(cmd_waiting, w_addr, w_data, left_out, right_out));
        rx_cur = rx_plan;
        pos    = 0;
        if (cmd_waiting) begin
          cmd_waiting  = 1'b0;
          cmd_carrying = 1'b1;
        end
      end else begin
        pos = pre + 1;
      end
      if (pre == 55) cmd_carrying = 1'b0;
      if (acc) begin
        cmd_waiting = 1'b1;
        w_addr      = cmd_addr;
        w_data      = cmd_data;
      end
      exp_cmd_ready = !(cmd_waiting || cmd_carrying);
      rtag = rx_cur[55:40];
      if (pre == 0) exp_codec = rtag[15];
      if (pre == 96 && rtag[15] && rtag[12] && rtag[11]) begin
        exp_left  = rx_cur[39:20];
        exp_right = rx_cur[19:0];
        exp_ready = 1'b1;
      end
    end
    #1;
    check("ready", 256'(ready), 256'(exp_ready));
    check("codec_ready", 256'(codec_ready), 256'(exp_codec));
    check("cmd_ready", 256'(cmd_ready), 256'(exp_cmd_ready));
    check("left_in", 256'(left_in), 256'(exp_left));
    check("right_in", 256'(right_in), 256'(exp_right));
    if (pos >= 0) begin
      obs_sync[255-pos] = sync;
      obs_tx[255-pos]   = sdata_out;
      if (pos == 255) begin
        check("sync_frame", obs_sync, {16'hFFFF, 240'h0});
        if (exp_q.size() == 0) begin
          check("tx_queue", 256'(exp_q.size()), 256'd1);
        end else begin
          exp_frame = exp_q.pop_front();
          check("tx_frame", obs_tx, {exp_frame, 160'h0});
        end
      end
    end
  end

  // Codec side: slots 0/3/4 from the plan, random noise everywhere else.
  always @(negedge clock) begin
    if (pos >= 0 && pos < 16)        sdata_in = rx_cur[55-pos];
    else if (pos >= 56 && pos < 96)  sdata_in = rx_cur[95-pos];
    else                             sdata_in = 1'($urandom_range(0, 1));
  end

  task automatic run_frames(input int n);
    repeat (n * 256) @(negedge clock);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (pos == p) return;
    end
    check("wait_pos", 256'(pos), 256'(p));
  endtask

  task automatic send_cmd(input logic [6:0] a, input logic [15:0] d);
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (cmd_ready) begin
        @(negedge clock);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    check("cmd_handshake", 256'(cmd_ready), 256'd1);
  endtask

  task automatic pulse_reset_at(input int p);
    wait_pos(p);
    reset_n = 1'b0;
    #1;
    check("rst_sync", 256'(sync), 256'd0);
    check("rst_sdata_out", 256'(sdata_out), 256'd0);
    check("rst_ready", 256'(ready), 256'd0);
    check("rst_cmd_ready", 256'(cmd_ready), 256'd0);
    check("rst_left_in", 256'(left_in), 256'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] tag;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Idle link: no ready strobes, plain 9800 tags.
    run_frames(3);

    left_out  = 20'hABCDE;
    right_out = 20'h12345;
    rx_plan   = {16'h9800, 20'h0F0F0, 20'hFFFFF};
    run_frames(2);

    // Tag with PCM-left valid clear: samples must hold.
    rx_plan = {16'h8800, 20'h12345, 20'h54321};
    run_frames(2);

    rx_plan = {16'h9800, 20'h0F0F0, 20'hFFFFF};
    wait_pos(100);
    send_cmd(7'h02, 16'h0808);
    run_frames(2);

    // Command accepted on the frame-start edge goes out one frame later.
    wait_pos(255);
    cmd_addr  = 7'h55;
    cmd_data  = 16'hBEEF;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    run_frames(2);

    for (int i = 0; i < 6; i++) begin
      left_out  = 20'($urandom);
      right_out = 20'($urandom);
      tag = 16'($urandom);
      if ($urandom_range(0, 3) != 0) tag = tag | 16'h9800;
      rx_plan = {tag, 20'($urandom), 20'($urandom)};
      wait_pos(int'($urandom_range(1, 250)));
      send_cmd(7'($urandom), 16'($urandom));
    end
    run_frames(2);

    rx_plan = {16'h9800, 20'h13579, 20'h2468A};
    run_frames(2);
    wait_pos(10);
    send_cmd(7'h7F, 16'hA5A5);
    pulse_reset_at(40);
    run_frames(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
